fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of imem. Owns the program counter, drives the

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_pc_gen.sv | 29 ++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    localparam int          PC_STEP   = 4;
    localparam logic [31:0] INSTR_NOP = 32'hD503201F;

    // A fetch target must be word aligned; any low-bit set is fatal.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection for the fetch stage: hold, sequential step, or redirect.
// Also flags a redirect whose target is not word aligned.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 64
) (
    input  logic [PC_WIDTH-1:0] pc_q,
    input  logic                run,
    input  logic                load,
    input  logic                br_valid,
    input  logic [PC_WIDTH-1:0] br_target,
    output logic [PC_WIDTH-1:0] pc_d,
    output logic                redirect,
    output logic                misalign
);

    // Misaligned redirect beats aligned redirect beats sequential step; otherwise hold.
    always_comb begin
        misalign = run && br_valid && is_misaligned(br_target[1:0]);
        redirect = run && br_valid && !misalign;
        pc_d     = pc_q;
        if (redirect)
            pc_d = br_target;
        else if (load && !misalign)
            pc_d = pc_q + PC_WIDTH'(PC_STEP);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses imem, registers the fetched
// word with its PC and hands it to decode over valid/ready.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH   = 64,
    parameter int                  ADDR_WIDTH = 6,
    parameter int                  DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_q,
    input  logic                  br_valid,
    input  logic [PC_WIDTH-1:0]   br_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic                  halted,
    output logic                  err_misalign
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]           fetch_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    fetch_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [PC_WIDTH-1:0]   out_pc_q, out_pc_d;
    logic                  halted_q, halted_d;
    logic                  err_q, err_d;

    logic run, load, redirect, misalign;

    // imem is read combinationally from the current PC, wrapping within its depth.
    assign imem_addr = pc_q[ADDR_WIDTH+1:2];

    fetch_pc_gen #(.PC_WIDTH(PC_WIDTH)) u_pc_gen (
        .pc_q      (pc_q),
        .run       (run),
        .load      (load),
        .br_valid  (br_valid),
        .br_target (br_target),
        .pc_d      (pc_d),
        .redirect  (redirect),
        .misalign  (misalign)
    );

    // Load decision, FSM next state and output-register next values.
    always_comb begin
        run  = (state_q == S_RUN);
        // Any redirect request (aligned or not) suppresses the load that cycle.
        load = run && !br_valid && fetch_en && (!out_valid_q || out_ready);

        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (misalign) state_d = S_HALT;
            default: state_d = state_q;
        endcase

        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (state_q == S_HALT || misalign || redirect) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_instr_d = imem_q;
            out_pc_d    = pc_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        halted_d = (state_d == S_HALT);
        err_d    = err_q | misalign;
    end

    // All fetch-stage state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign halted       = halted_q;
    assign err_misalign = err_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counters freeze once halted; a stall is any cycle holding an unaccepted word.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(load);
        stall_cnt_d = stall_cnt_q;
        if (state_q != S_HALT && out_valid_q && !out_ready)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    // Performance counters not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a behavioural imem array.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int PCW = 64;
    localparam int AW  = 6;
    localparam int DW  = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           fetch_en = 1'b0;
    logic           out_ready = 1'b0;
    logic           br_valid = 1'b0;
    logic [PCW-1:0] br_target = '0;
    logic [AW-1:0]  imem_addr;
    logic [DW-1:0]  imem_q;
    logic           out_valid;
    logic [DW-1:0]  out_instr;
    logic [PCW-1:0] out_pc;
    logic           halted;
    logic           err_misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]    fetch_cnt;
    logic [31:0]    stall_cnt;
`endif

    always #5 clk = ~clk;

    logic [DW-1:0] mem [64];
    assign imem_q = mem[imem_addr];

    fetch_unit dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_q(imem_q),
        .br_valid(br_valid), .br_target(br_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .halted(halted), .err_misalign(err_misalign)
`ifdef FETCH_PERF_CNT_EN
       ,.fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } txn_t;

    txn_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: what decode should see, in plain terms.
    logic [63:0] m_pc;
    bit          m_valid, m_boot, m_halt, m_err;
    int unsigned m_fcnt, m_scnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_valid = 0; m_boot = 1; m_halt = 0; m_err = 0;
        m_fcnt = 0; m_scnt = 0;
        exp_q.delete();
    endtask

    // One rising edge of the reference: boot cycle, then redirect / fetch / accept.
    task automatic model_step();
        if (m_halt) return;
        if (m_boot) begin m_boot = 0; return; end
        if (m_valid && !out_ready) m_scnt++;
        if (br_valid) begin
            // An unaccepted word is flushed; an accepted one was already popped.
            if (m_valid && !out_ready && exp_q.size() > 0) void'(exp_q.pop_back());
            m_valid = 0;
            if (br_target[1:0] != 2'b00) begin m_halt = 1; m_err = 1; end
            else m_pc = br_target;
        end else if (fetch_en && (!m_valid || out_ready)) begin
            exp_q.push_back('{pc: m_pc, instr: mem[m_pc[7:2]]});
            m_valid = 1;
            m_pc    = m_pc + 64'd4;
            m_fcnt++;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    task automatic drive(input logic fe, input logic rdy, input logic bv, input logic [63:0] bt);
        fetch_en = fe; out_ready = rdy; br_valid = bv; br_target = bt;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},  out_valid, 0);
        chk({tag, "_instr"},  out_instr, 0);
        chk({tag, "_pc"},     out_pc, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_err"},    err_misalign, 0);
        chk({tag, "_addr"},   imem_addr, 0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_fcnt"},   fetch_cnt, 0);
        chk({tag, "_scnt"},   stall_cnt, 0);
`endif
    endtask

    // Assert reset away from a clock edge, check async clear, release after an edge.
    task automatic reset_dut(input string tag);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk_reset_outputs(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare against the model and pop the scoreboard on each handshake.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", out_valid, m_valid);
            chk("halted", halted, m_halt);
            chk("err_misalign", err_misalign, m_err);
            chk("imem_addr", imem_addr, m_pc[7:2]);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL scoreboard: output valid at pc %h but none expected", out_pc);
                end else begin
                    chk("out_pc", out_pc, exp_q[0].pc);
                    chk("out_instr", out_instr, exp_q[0].instr);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] w10;
        logic [63:0]   tgt;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        w10 = mem[10];
        model_reset();

        // Reset state while reset is held.
        #12;
        chk_reset_outputs("rst");
        @(posedge clk); #1; reset = 1'b0;

        // Streaming fetch: boot cycle then pc 0,4,8.
        drive(1, 1, 0, 0);
        repeat (4) step();
        chk("run_pc8", out_pc, 64'h8);

        // Stall three cycles on pc 8, then release.
        out_ready = 1'b0;
        repeat (3) step();
        chk("stall_pc", out_pc, 64'h8);
        chk("stall_addr", imem_addr, 3);
        out_ready = 1'b1;
        step();
        chk("release_pc", out_pc, 64'hC);

        // Redirect to 0x28.
        drive(1, 1, 1, 64'h28);
        step();
        chk("br_flush", out_valid, 0);
        br_valid = 1'b0;
        step();
        chk("br_pc", out_pc, 64'h28);
        chk("br_instr", out_instr, w10);

        // Wrap of imem address across 0xFC -> 0x100.
        drive(1, 1, 1, 64'hF8);
        step();
        chk("wrap_addr62", imem_addr, 62);
        br_valid = 1'b0;
        repeat (3) step();
        chk("wrap_pc", out_pc, 64'h100);
        chk("wrap_addr1", imem_addr, 1);
        repeat (2) step();

        // Randomised traffic with occasional aligned redirects.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) tgt = {$urandom, $urandom} & ~64'h3;
            else tgt = 64'($urandom_range(0, 127)) * 4;
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, tgt);
            step();
        end

        // Misaligned redirect halts; later redirects are ignored.
        drive(1, $urandom_range(0, 1) != 0, 1, 64'h2A);
        step();
        chk("halt_flag", halted, 1);
        chk("halt_err", err_misalign, 1);
        for (int c = 0; c < 8; c++) begin
            drive(1, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                  64'($urandom_range(0, 63)) * 4);
            step();
        end
        chk("halt_valid", out_valid, 0);
        drive(0, 0, 0, 0);
        reset_dut("unhalt");

        // Ten loads then three stall cycles, then reset mid-stall.
        drive(1, 1, 0, 0);
        repeat (11) step();
        drive(0, 0, 0, 0);
        repeat (3) step();
        chk("stall_hold_valid", out_valid, 1);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, 32'd10);
        chk("stall_cnt", stall_cnt, 32'd3);
        chk("fetch_cnt_model", fetch_cnt, m_fcnt);
        chk("stall_cnt_model", stall_cnt, m_scnt);
`endif
        reset_dut("midstall");
        drive(1, 1, 0, 0);
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
